// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one cycle of stable ALU inputs in EXEC,
// then the captured result is held for the owner in RESP until consumed.
module alu_arbiter #(
  parameter int aluwidth = 8,
  parameter int opsize   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [opsize-1:0]   req0_op,
  input  logic [aluwidth-1:0] req0_a,
  input  logic [aluwidth-1:0] req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [opsize-1:0]   req1_op,
  input  logic [aluwidth-1:0] req1_a,
  input  logic [aluwidth-1:0] req1_b,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [aluwidth-1:0] resp0_data,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [aluwidth-1:0] resp1_data,
  output logic [opsize-1:0]   alu_op,
  output logic [aluwidth-1:0] alu_in1,
  output logic [aluwidth-1:0] alu_in2,
  input  logic [aluwidth-1:0] alu_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                r_owner;
  logic [aluwidth-1:0] r_result;
  logic [opsize-1:0]   r_alu_op;
  logic [aluwidth-1:0] r_alu_in1;
  logic [aluwidth-1:0] r_alu_in2;

  logic                w_grant;
  logic                w_any_valid;
  logic                w_accept;
  logic                w_owner_ready;

  // Grant selection: sole valid requester wins; a tie goes to the one not granted last.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_any_valid   = req0_valid | req1_valid;
  // A handshake can only happen in IDLE, and only the granted requester sees ready.
  assign w_accept      = (r_state == S_IDLE) && w_any_valid;
  assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (w_owner_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch the granted operands, remember the owner, capture the ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_result     <= '0;
      r_alu_op     <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_alu_op     <= w_grant ? req1_op : req0_op;
        r_alu_in1    <= w_grant ? req1_a  : req0_a;
        r_alu_in2    <= w_grant ? req1_b  : req0_b;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_out;
      end
    end
  end

  assign req0_ready  = w_accept && !w_grant;
  assign req1_ready  = w_accept &&  w_grant;
  assign resp0_valid = (r_state == S_RESP) && !r_owner;
  assign resp1_valid = (r_state == S_RESP) &&  r_owner;
  // The result register is shared; it is meaningful only while the matching valid is high.
  assign resp0_data  = r_result;
  assign resp1_data  = r_result;
  assign alu_op      = r_alu_op;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference of the arbiter.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int OW = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LS  = 3'd4;
  localparam logic [2:0] OP_RS  = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0]  resp0_data, resp1_data;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic          busy;

  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU.
  function automatic logic [W-1:0] alu_ref(input logic [OW-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_LS:   return x << y;
      OP_RS:   return x >> y;
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

  alu_arbiter #(.aluwidth(W), .opsize(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester-side drive state.
  logic          d_rst;
  logic          d_valid  [2];
  logic [OW-1:0] d_op     [2];
  logic [W-1:0]  d_a      [2];
  logic [W-1:0]  d_b      [2];
  logic          d_rready [2];

  // Reference: phase counts cycles since acceptance (0 none, 1 executing, 2 responding).
  int            m_phase;
  logic          m_owner, m_last;
  logic [W-1:0]  m_res, m_in1, m_in2;
  logic [OW-1:0] m_op;

  // DUT-observed handshakes, for order checks against fixed expectations.
  int            obs_grant[$];
  int            obs_resp_req[$];
  logic [W-1:0]  obs_resp_data[$];
  int            resp1_seen;

  task automatic model_reset();
    m_phase = 0; m_owner = 1'b0; m_last = 1'b1;
    m_res = '0; m_in1 = '0; m_in2 = '0; m_op = '0;
  endtask

  task automatic step();
    logic g, acc;
    @(negedge clk);
    reset       = d_rst;
    req0_valid  = d_valid[0]; req0_op = d_op[0]; req0_a = d_a[0]; req0_b = d_b[0];
    req1_valid  = d_valid[1]; req1_op = d_op[1]; req1_a = d_a[1]; req1_b = d_b[1];
    resp0_ready = d_rready[0];
    resp1_ready = d_rready[1];
    #1;
    g   = (d_valid[0] && d_valid[1]) ? ~m_last : d_valid[1];
    acc = (m_phase == 0) && (d_valid[0] || d_valid[1]);
    check_val("req0_ready",  req0_ready,  acc && !g);
    check_val("req1_ready",  req1_ready,  acc && g);
    check_val("resp0_valid", resp0_valid, (m_phase == 2) && !m_owner);
    check_val("resp1_valid", resp1_valid, (m_phase == 2) && m_owner);
    if (m_phase == 2 && !m_owner) check_val("resp0_data", resp0_data, m_res);
    if (m_phase == 2 &&  m_owner) check_val("resp1_data", resp1_data, m_res);
    check_val("busy",    busy,    m_phase != 0);
    check_val("alu_op",  alu_op,  m_op);
    check_val("alu_in1", alu_in1, m_in1);
    check_val("alu_in2", alu_in2, m_in2);
    if (req0_valid && req0_ready) obs_grant.push_back(0);
    if (req1_valid && req1_ready) obs_grant.push_back(1);
    if (resp1_valid) resp1_seen++;
    if (resp0_valid && resp0_ready) begin obs_resp_req.push_back(0); obs_resp_data.push_back(resp0_data); end
    if (resp1_valid && resp1_ready) begin obs_resp_req.push_back(1); obs_resp_data.push_back(resp1_data); end
    @(posedge clk);
    if (d_rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (acc) begin
        m_owner = g; m_last = g;
        m_op = d_op[g]; m_in1 = d_a[g]; m_in2 = d_b[g];
        m_res = alu_ref(d_op[g], d_a[g], d_b[g]);
        m_phase = 1;
        $display("txn req%0d op=%0d a=%0d b=%0d expect=%0d", g, d_op[g], d_a[g], d_b[g], m_res);
        d_valid[g] = 1'b0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (d_rready[m_owner]) begin
      m_phase = 0;
    end
  endtask

  task automatic load(input int n, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    d_valid[n] = 1'b1; d_op[n] = op; d_a[n] = a; d_b[n] = b;
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    d_valid[0] = 1'b0; d_valid[1] = 1'b0;
    step(); step();
    d_rst = 1'b0;
    obs_grant.delete(); obs_resp_req.delete(); obs_resp_data.delete();
    resp1_seen = 0;
  endtask

  initial begin
    int issued;
    d_rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      d_valid[n] = 1'b0; d_op[n] = '0; d_a[n] = '0; d_b[n] = '0; d_rready[n] = 1'b1;
    end
    model_reset();
    resp1_seen = 0;

    // Reset: idle with no valid, every output zero.
    do_reset();
    step();
    check_val("rst_resp0_data", resp0_data, 0);
    check_val("rst_resp1_data", resp1_data, 0);

    // Single ADD from req0.
    load(0, OP_ADD, 8'd5, 8'd2);
    repeat (4) step();
    check_val("add_n", obs_resp_data.size(), 1);
    if (obs_resp_data.size() == 1) check_val("add_data", obs_resp_data[0], 7);

    // Tie after reset: req0 first.
    do_reset();
    load(0, OP_SUB, 8'd5, 8'd2);
    load(1, OP_AND, 8'd5, 8'd2);
    repeat (7) step();
    check_val("tie_n", obs_resp_data.size(), 2);
    if (obs_resp_data.size() == 2) begin
      check_val("tie_first_req",  obs_resp_req[0],  0);
      check_val("tie_first_data", obs_resp_data[0], 3);
      check_val("tie_second_req", obs_resp_req[1],  1);
      check_val("tie_second_data", obs_resp_data[1], 0);
    end

    // Both requesters saturated: alternating grants.
    do_reset();
    load(0, OP_OR, 8'd5, 8'd2);
    load(1, OP_OR, 8'd5, 8'd2);
    issued = 2;
    for (int c = 0; c < 30 && obs_resp_data.size() < 4; c++) begin
      step();
      for (int n = 0; n < 2; n++)
        if (!d_valid[n] && issued < 4) begin load(n, OP_OR, 8'd5, 8'd2); issued++; end
    end
    check_val("rr_n", obs_resp_data.size(), 4);
    for (int i = 0; i < 4 && i < obs_grant.size(); i++) check_val("rr_order", obs_grant[i], i % 2);
    for (int i = 0; i < obs_resp_data.size(); i++) check_val("rr_data", obs_resp_data[i], 7);

    // Response stall blocks further grants.
    do_reset();
    load(0, OP_ADD, 8'd5, 8'd2);
    load(1, OP_ADD, 8'd1, 8'd1);
    d_rready[0] = 1'b0;
    repeat (5) step();
    check_val("stall_grants", obs_grant.size(), 1);
    d_rready[0] = 1'b1;
    repeat (5) step();
    check_val("stall_grants_after", obs_grant.size(), 2);
    if (obs_grant.size() == 2) check_val("stall_second", obs_grant[1], 1);

    // Reset during EXEC drops the transaction and clears last_grant.
    do_reset();
    load(1, OP_ADD, 8'd5, 8'd2);
    step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    repeat (3) step();
    check_val("drop_resp1", resp1_seen, 0);
    obs_grant.delete();
    load(0, OP_OR, 8'd1, 8'd2);
    load(1, OP_OR, 8'd3, 8'd4);
    step();
    check_val("drop_next_grant", obs_grant.size() > 0 ? obs_grant[0] : 9, 0);
    repeat (6) step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!d_valid[n] && ($urandom_range(0, 2) == 0))
          load(n, OW'($urandom_range(0, 5)), W'($urandom), W'($urandom_range(0, 9)));
        else if (d_valid[n] && ($urandom_range(0, 15) == 0))
          d_valid[n] = 1'b0;
        d_rready[n] = ($urandom_range(0, 3) != 0);
      end
      d_rst = ($urandom_range(0, 60) == 0);
      step();
    end
    d_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
